// File: rtl/cpu_if_pkg.sv
// Shared definitions for the CPU-to-cache bridge: default widths,
// FSM state encoding and the request-direction helper.
package cpu_if_pkg;

    localparam int AW_DEF   = 16;
    localparam int DW_DEF   = 32;
    localparam int BW_DEF   = 4;
    localparam int SYNC_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Returns {wr, rd}; a simultaneous write and read strobe is treated as a write.
    function automatic logic [1:0] req_dir(input logic wr, input logic rd);
        return {wr, rd & ~wr};
    endfunction

endpackage

// File: rtl/cpu_if_sync_ff.sv
// Multi-flop bit synchronizer used to bring the asynchronous c_ack level
// into the sys_clk domain. Reset clears the whole chain.
module sync_ff #(
    parameter int SYNC = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC-1:0] sync_q;

    // Shift the asynchronous input through SYNC flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC-1];

endmodule

// File: rtl/cpu_if.sv
// CPU bus to cache port bridge: latches one request, runs a 4-phase
// req/ack handshake against the synchronized c_ack and returns read data
// with a single-cycle sys_ack.
module cpu_if
    import cpu_if_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int BW   = BW_DEF,
    parameter int SYNC = SYNC_DEF
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          c_clk,
    input  logic [AW-1:0] sys_addr,
    input  logic          sys_wr,
    input  logic          sys_rd,
    input  logic [DW-1:0] sys_wdata,
    input  logic [BW-1:0] sys_bval,
    input  logic [DW-1:0] c_rdata,
    input  logic          c_ack,
    output logic [AW-1:0] c_addr,
    output logic          c_wr,
    output logic          c_rd,
    output logic [DW-1:0] c_wdata,
    output logic [BW-1:0] c_bval,
    output logic [DW-1:0] sys_rdata,
    output logic          sys_ack
);

    // c_clk only exists for pin compatibility with the cache side.
    logic c_clk_unused;
    assign c_clk_unused = c_clk;

    state_e        state_q, state_d;
    logic          ack_s;
    logic          accept;
    logic [AW-1:0] c_addr_q, c_addr_d;
    logic [DW-1:0] c_wdata_q, c_wdata_d;
    logic [BW-1:0] c_bval_q, c_bval_d;
    logic          c_wr_q, c_wr_d;
    logic          c_rd_q, c_rd_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          sys_ack_q, sys_ack_d;

    sync_ff #(.SYNC(SYNC)) u_ack_sync (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (c_ack),
        .q_o   (ack_s)
    );

    // A strobe is only taken in IDLE once the previous handshake has fully closed.
    assign accept = (state_q == ST_IDLE) && (sys_wr || sys_rd) && !ack_s;

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the 4-phase handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ:  if (ack_s)  state_d = ST_WAIT;
            ST_WAIT: if (!ack_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values: request latch, request levels, read capture and ack pulse.
    always_comb begin
        c_addr_d  = c_addr_q;
        c_wdata_d = c_wdata_q;
        c_bval_d  = c_bval_q;
        c_wr_d    = c_wr_q;
        c_rd_d    = c_rd_q;
        rdata_d   = rdata_q;
        sys_ack_d = 1'b0;
        if (accept) begin
            c_addr_d         = sys_addr;
            c_wdata_d        = sys_wdata;
            c_bval_d         = sys_bval;
            {c_wr_d, c_rd_d} = req_dir(sys_wr, sys_rd);
        end else if (state_q == ST_REQ && ack_s) begin
            c_wr_d    = 1'b0;
            c_rd_d    = 1'b0;
            sys_ack_d = 1'b1;
            if (c_rd_q) rdata_d = c_rdata;
        end
    end

    // Output registers; reset drops any in-flight request and clears every output.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            c_addr_q  <= '0;
            c_wdata_q <= '0;
            c_bval_q  <= '0;
            c_wr_q    <= 1'b0;
            c_rd_q    <= 1'b0;
            rdata_q   <= '0;
            sys_ack_q <= 1'b0;
        end else begin
            c_addr_q  <= c_addr_d;
            c_wdata_q <= c_wdata_d;
            c_bval_q  <= c_bval_d;
            c_wr_q    <= c_wr_d;
            c_rd_q    <= c_rd_d;
            rdata_q   <= rdata_d;
            sys_ack_q <= sys_ack_d;
        end
    end

    assign c_addr    = c_addr_q;
    assign c_wdata   = c_wdata_q;
    assign c_bval    = c_bval_q;
    assign c_wr      = c_wr_q;
    assign c_rd      = c_rd_q;
    assign sys_rdata = rdata_q;
    assign sys_ack   = sys_ack_q;

endmodule

// File: tb/tb_cpu_if.sv
// Scoreboard bench for cpu_if: stimulus pushes expected cache requests and
// CPU completions into queues; a monitor pops and compares on DUT events.
module tb_cpu_if;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bval;
    } req_t;

    logic        sys_clk = 1'b0;
    logic        c_clk   = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] sys_addr  = '0;
    logic        sys_wr    = 1'b0;
    logic        sys_rd    = 1'b0;
    logic [31:0] sys_wdata = '0;
    logic [3:0]  sys_bval  = '0;
    logic [31:0] c_rdata   = '0;
    logic        c_ack     = 1'b0;
    logic [15:0] c_addr;
    logic        c_wr, c_rd;
    logic [31:0] c_wdata;
    logic [3:0]  c_bval;
    logic [31:0] sys_rdata;
    logic        sys_ack;

    int n_tests = 0;
    int n_fail  = 0;

    req_t        req_q[$];
    logic [31:0] ack_q[$];
    logic [31:0] last_rdata = '0;

    always #5 sys_clk = ~sys_clk;
    always #7 c_clk   = ~c_clk;

    cpu_if dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .c_clk     (c_clk),
        .sys_addr  (sys_addr),
        .sys_wr    (sys_wr),
        .sys_rd    (sys_rd),
        .sys_wdata (sys_wdata),
        .sys_bval  (sys_bval),
        .c_rdata   (c_rdata),
        .c_ack     (c_ack),
        .c_addr    (c_addr),
        .c_wr      (c_wr),
        .c_rd      (c_rd),
        .c_wdata   (c_wdata),
        .c_bval    (c_bval),
        .sys_rdata (sys_rdata),
        .sys_ack   (sys_ack)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one strobe for one cycle; expected request and completion go to the scoreboard.
    task automatic issue(input bit wr, input bit rd, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] b, input logic [31:0] rdat);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = d; r.bval = b;
        req_q.push_back(r);
        if (!wr) last_rdata = rdat;
        ack_q.push_back(last_rdata);
        @(posedge sys_clk); #2;
        sys_wr = wr; sys_rd = rd; sys_addr = a; sys_wdata = d; sys_bval = b;
        @(posedge sys_clk); #2;
        sys_wr = 1'b0; sys_rd = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!(c_wr || c_rd) && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        if (!(c_wr || c_rd)) check("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic cache_ack(input logic [31:0] d);
        @(posedge sys_clk); #2;
        c_rdata = d;
        c_ack   = 1'b1;
        #32;
        c_ack   = 1'b0;
        repeat (8) @(posedge sys_clk);
    endtask

    // Monitor: compares cache requests and CPU completions against the queues.
    initial begin
        bit   prev_act = 1'b0;
        bit   prev_ack = 1'b0;
        bit   act;
        req_t cur;
        cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0; cur.bval = '0;
        forever begin
            @(negedge sys_clk);
            act = c_wr || c_rd;
            if (act && !prev_act) begin
                if (req_q.size() == 0) check("unexpected_req", 64'd1, 64'd0);
                else cur = req_q.pop_front();
            end
            if (act)
                check("req_hold", 64'({c_wr, c_rd, c_addr, c_wdata, c_bval}),
                      64'({cur.wr, ~cur.wr, cur.addr, cur.wdata, cur.bval}));
            if (sys_ack) begin
                if (prev_ack) check("ack_width", 64'd2, 64'd1);
                if (ack_q.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
                else check("sys_rdata", 64'(sys_rdata), 64'(ack_q.pop_front()));
            end
            prev_act = act;
            prev_ack = sys_ack;
        end
    end

    // Directed stimulus.
    initial begin
        logic [15:0] ra;
        // Reset with a write strobe held
        sys_wr = 1'b1;
        #20;
        check("reset_outputs", 64'({c_addr, c_wdata, c_bval, c_wr, c_rd, sys_ack}), 64'd0);
        check("reset_rdata", 64'(sys_rdata), 64'd0);
        @(posedge sys_clk); #2;
        sys_rst = 1'b0;
        sys_wr  = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("no_wr_after_reset", 64'(c_wr), 64'd0);

        // Write
        issue(1'b1, 1'b0, 16'h010F, 32'h00012343, 4'b0010, '0);
        wait_req();
        repeat (3) @(negedge sys_clk);
        check("wr_held_no_ack", 64'(c_wr), 64'd1);
        cache_ack(32'hFFFF_0000);
        check("wr_dropped", 64'(c_wr), 64'd0);

        // Read
        issue(1'b0, 1'b1, 16'h0200, 32'hDEADBEEF, 4'b1111, 32'h001234AB);
        wait_req();
        cache_ack(32'h001234AB);
        check("rd_dropped", 64'(c_rd), 64'd0);

        // Back-to-back write with random address; read data must stay unchanged
        ra = 16'($urandom);
        issue(1'b1, 1'b0, ra, 32'hCAFE0001, 4'b1100, '0);
        wait_req();
        cache_ack(32'h0BAD0BAD);

        // Simultaneous strobes resolve to a write
        issue(1'b1, 1'b1, 16'h0ABC, 32'h13572468, 4'b0101, '0);
        wait_req();
        cache_ack(32'h0);

        // Busy strobe during REQ is ignored
        issue(1'b0, 1'b1, 16'h0300, 32'h00000011, 4'b0001, 32'h55AA55AA);
        wait_req();
        @(posedge sys_clk); #2;
        sys_rd = 1'b1; sys_addr = 16'h7777; sys_wdata = 32'h99999999; sys_bval = 4'b1000;
        @(posedge sys_clk); #2;
        sys_rd = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("busy_addr", 64'(c_addr), 64'h0300);
        cache_ack(32'h55AA55AA);
        check("busy_rdata", 64'(sys_rdata), 64'h55AA55AA);

        // Mid-operation reset: request dropped, later c_ack yields no sys_ack
        issue(1'b1, 1'b0, 16'h0444, 32'h44444444, 4'b1111, '0);
        void'(ack_q.pop_back());
        wait_req();
        @(posedge sys_clk); #2;
        sys_rst = 1'b1;
        #1;
        check("midrst_req", 64'({c_wr, c_rd}), 64'd0);
        check("midrst_addr", 64'(c_addr), 64'd0);
        last_rdata = '0;
        @(posedge sys_clk); #2;
        sys_rst = 1'b0;
        cache_ack(32'h77777777);
        repeat (4) @(negedge sys_clk);
        check("midrst_rdata", 64'(sys_rdata), 64'd0);

        check("req_q_drained", 64'(req_q.size()), 64'd0);
        check("ack_q_drained", 64'(ack_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
